player_collision_ctl: RTL



---
 rtl/player_collision_pkg.sv | 27 ++
 rtl/box_hit_compare.sv | 67 ++++++
 rtl/player_collision_ctl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/player_collision_pkg.sv
// Shared game package: FSM state encoding, HP default, game-field bounds
// and a small pixel-validity helper used by the hitbox comparators.
package player_collision_pkg;

  // Two-bit game state encoding
  typedef logic [1:0] game_state_t;

  localparam game_state_t ST_IDLE  = 2'd0;
  localparam game_state_t ST_ALIVE = 2'd1;
  localparam game_state_t ST_INVUL = 2'd2;
  localparam game_state_t ST_DEAD  = 2'd3;

  // HP loaded at the start of every game
  localparam int DEFAULT_MAX_HP = 5;

  // Game-field bounds shared with the obstacle blocks
  localparam logic [11:0] FIELD_X_MIN = 12'd317;
  localparam logic [11:0] FIELD_X_MAX = 12'd617;
  localparam logic [11:0] FIELD_Y_MIN = 12'd361;
  localparam logic [11:0] FIELD_Y_MAX = 12'd661;

  // Obstacle stages output (0,0) when no obstacle pixel is being drawn
  function automatic logic pixel_valid(input logic [11:0] x, input logic [11:0] y);
    return (x != 12'd0) || (y != 12'd0);
  endfunction

endpackage

// File: rtl/box_hit_compare.sv
// Two-stage pixel-versus-square comparator. Stage 1 registers the pixel and
// box corner, stage 2 registers the containment result. Upper bounds use
// 13-bit arithmetic so a box near x/y = 4095 does not wrap to small values.
module box_hit_compare
  import player_collision_pkg::*;
#(
  parameter int BOX_SIZE = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] px,
  input  logic [11:0] py,
  input  logic [11:0] box_x,
  input  logic [11:0] box_y,
  output logic        hit_flag
);

  localparam logic [12:0] SPAN = 13'(BOX_SIZE - 1);

  logic [11:0] px_r;
  logic [11:0] py_r;
  logic [11:0] box_x_r;
  logic [11:0] box_y_r;
  logic        hit_r;

  logic [12:0] x_hi_s;
  logic [12:0] y_hi_s;
  logic        in_x_s;
  logic        in_y_s;
  logic        hit_nxt_s;

  // Stage 1: capture the incoming pixel and the box corner together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      px_r    <= 12'd0;
      py_r    <= 12'd0;
      box_x_r <= 12'd0;
      box_y_r <= 12'd0;
    end else begin
      px_r    <= px;
      py_r    <= py;
      box_x_r <= box_x;
      box_y_r <= box_y;
    end
  end

  // Containment test on the stage-1 values with widened upper bounds
  always_comb begin
    x_hi_s    = {1'b0, box_x_r} + SPAN;
    y_hi_s    = {1'b0, box_y_r} + SPAN;
    in_x_s    = (px_r >= box_x_r) && ({1'b0, px_r} <= x_hi_s);
    in_y_s    = (py_r >= box_y_r) && ({1'b0, py_r} <= y_hi_s);
    hit_nxt_s = pixel_valid(px_r, py_r) && in_x_s && in_y_s;
  end

  // Stage 2: register the collision flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r <= 1'b0;
    end else begin
      hit_r <= hit_nxt_s;
    end
  end

  assign hit_flag = hit_r;

endmodule

// File: rtl/player_collision_ctl.sv
// Player collision controller: turns obstacle-pixel hits on the player
// square into HP loss, a one-cycle hit pulse, a post-hit invulnerability
// window and a game-over flag. All outputs are registered.
module player_collision_ctl
  import player_collision_pkg::*;
#(
  parameter int PLAYER_SIZE = 10,
  parameter int MAX_HP      = DEFAULT_MAX_HP,
  parameter int INVUL_TIME  = 65_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] obstacle_x,
  input  logic [11:0] obstacle_y,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        play_selected,
  input  logic        menu_on,
  output logic [3:0]  hp,
  output logic        hit,
  output logic        invulnerable,
  output logic        game_over
);

  localparam logic [3:0]  HP_FULL    = 4'(MAX_HP);
  localparam logic [26:0] INVUL_LAST = 27'(INVUL_TIME - 1);

  game_state_t state_r;
  game_state_t state_nxt_s;
  logic [26:0] timer_r;
  logic [26:0] timer_nxt_s;
  logic [3:0]  hp_r;
  logic [3:0]  hp_nxt_s;
  logic        hit_r;
  logic        hit_nxt_s;
  logic        invul_r;
  logic        invul_nxt_s;
  logic        game_over_r;
  logic        game_over_nxt_s;
  logic        coll_s;
  logic        abort_s;

  box_hit_compare #(
    .BOX_SIZE (PLAYER_SIZE)
  ) u_box_hit_compare (
    .clk      (clk),
    .rst_n    (rst_n),
    .px       (obstacle_x),
    .py       (obstacle_y),
    .box_x    (mouse_xpos),
    .box_y    (mouse_ypos),
    .hit_flag (coll_s)
  );

  assign abort_s = menu_on || !play_selected;

  // State, HP and timer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      timer_r <= 27'd0;
      hp_r    <= HP_FULL;
    end else begin
      state_r <= state_nxt_s;
      timer_r <= timer_nxt_s;
      hp_r    <= hp_nxt_s;
    end
  end

  // Next-state, next-HP and timer logic; abort outranks a collision
  always_comb begin
    state_nxt_s = state_r;
    timer_nxt_s = timer_r;
    hp_nxt_s    = hp_r;
    case (state_r)
      ST_IDLE: begin
        hp_nxt_s    = HP_FULL;
        timer_nxt_s = 27'd0;
        if (play_selected && !menu_on) begin
          state_nxt_s = ST_ALIVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ALIVE: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
          hp_nxt_s    = HP_FULL;
          timer_nxt_s = 27'd0;
        end else if (coll_s) begin
          timer_nxt_s = 27'd0;
          if (hp_r <= 4'd1) begin
            state_nxt_s = ST_DEAD;
            hp_nxt_s    = 4'd0;
          end else begin
            state_nxt_s = ST_INVUL;
            hp_nxt_s    = hp_r - 4'd1;
          end
        end else begin
          state_nxt_s = ST_ALIVE;
        end
      end
      ST_INVUL: begin
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
          hp_nxt_s    = HP_FULL;
          timer_nxt_s = 27'd0;
        end else if (timer_r == INVUL_LAST) begin
          state_nxt_s = ST_ALIVE;
          timer_nxt_s = 27'd0;
        end else begin
          state_nxt_s = ST_INVUL;
          timer_nxt_s = timer_r + 27'd1;
        end
      end
      ST_DEAD: begin
        hp_nxt_s = 4'd0;
        if (abort_s) begin
          state_nxt_s = ST_IDLE;
          hp_nxt_s    = HP_FULL;
        end else begin
          state_nxt_s = ST_DEAD;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        hp_nxt_s    = HP_FULL;
        timer_nxt_s = 27'd0;
      end
    endcase
  end

  // Output decode from the transition being taken this cycle
  always_comb begin
    hit_nxt_s       = 1'b0;
    invul_nxt_s     = 1'b0;
    game_over_nxt_s = 1'b0;
    case (state_nxt_s)
      ST_INVUL: begin
        invul_nxt_s = 1'b1;
        hit_nxt_s   = (state_r == ST_ALIVE);
      end
      ST_DEAD: begin
        game_over_nxt_s = 1'b1;
        hit_nxt_s       = (state_r == ST_ALIVE);
      end
      default: begin
        hit_nxt_s       = 1'b0;
        invul_nxt_s     = 1'b0;
        game_over_nxt_s = 1'b0;
      end
    endcase
  end

  // Registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_r       <= 1'b0;
      invul_r     <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      hit_r       <= hit_nxt_s;
      invul_r     <= invul_nxt_s;
      game_over_r <= game_over_nxt_s;
    end
  end

  assign hp           = hp_r;
  assign hit          = hit_r;
  assign invulnerable = invul_r;
  assign game_over    = game_over_r;

endmodule
